// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults and derived widths for the synchronous FIFO
package sync_fifo_pkg;

   // Default word width and number of storage entries.
   localparam int DATA_WIDTH_DEF = 8;
   localparam int DEPTH_DEF      = 16;

   // Address width for the default depth; pointers carry one extra wrap bit.
   localparam int ADDR_W         = $clog2(DEPTH_DEF);
   localparam int PTR_W          = ADDR_W + 1;

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - handshake and data bundle between a FIFO user and the FIFO
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 8
) (
   input logic clk
);

   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic                  full;
   logic                  empty;

   // Producer/consumer side: issues requests and write data, observes flags and read data.
   modport master (
      input  clk,
      output wr_en,
      output rd_en,
      output din,
      input  dout,
      input  full,
      input  empty
   );

   // FIFO side: receives requests and write data, returns flags and read data.
   modport slave (
      input  clk,
      input  wr_en,
      input  rd_en,
      input  din,
      output dout,
      output full,
      output empty
   );

endinterface

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - storage array with one synchronous write port and one registered read port
module sync_fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_W     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   // The array itself is never cleared; entries are only observable after a write.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port: store the incoming word when the controller accepts a write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port: the output register reloads only on an accepted read and clears on reset.
   // The controller never reads and writes the same entry on one edge, so no bypass is needed.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO: pointer/flag control around a registered-read storage array
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one bit beyond the address so full and empty are distinguishable.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        wr_acc;
   logic        rd_acc;

   // Flags come straight from the registered pointers, so they reflect the previous edge.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // Acceptance uses the pre-edge flags: a full FIFO drops writes, an empty one ignores reads.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   // Pointer registers: reset wins over any request; otherwise advance on accepted accesses.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   sync_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (AW)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (wr_acc && !reset),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (din),
      .re    (rd_acc),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (dout)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed scoreboard bench for sync_fifo
module tb_sync_fifo;

   logic clk = 1'b0;
   logic reset;

   sync_fifo_if #(.DATA_WIDTH(8)) bus (.clk(clk));

   sync_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .wr_en (bus.wr_en),
      .rd_en (bus.rd_en),
      .din   (bus.din),
      .dout  (bus.dout),
      .full  (bus.full),
      .empty (bus.empty)
   );

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q [$];
   logic [7:0] cur_exp = 8'h00;
   bit         rd_expected = 1'b0;
   bit         fire_q = 1'b0;
   bit         mon_en = 1'b0;

   initial forever #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: latch whether a dout update was expected at this edge.
   always @(posedge clk) fire_q <= rd_expected;

   // Monitor: away from the edge, pop the expected word when due and compare dout every cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (fire_q) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard_underrun: got no expected entry, required one");
            end else begin
               cur_exp = exp_q.pop_front();
            end
         end
         total++;
         if (bus.dout !== cur_exp) begin
            bad++;
            $display("FAIL dout: got %02h required %02h at %0t", bus.dout, cur_exp, $time);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // One clock: apply inputs, register the expected dout load, return 1 time unit after the edge.
   task automatic step(input logic rst, input logic w, input logic r, input logic [7:0] d,
                       input bit exp_rd, input logic [7:0] exp_val);
      reset       = rst;
      bus.wr_en   = w;
      bus.rd_en   = r;
      bus.din     = d;
      rd_expected = exp_rd;
      if (exp_rd) exp_q.push_back(exp_val);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      bus.wr_en  = 1'b0;
      bus.rd_en  = 1'b0;
      bus.din    = 8'h00;

      // Reset for two cycles; each reset edge loads dout with zero.
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
      mon_en = 1'b1;
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
      chk("reset_empty", 32'(bus.empty), 32'd1);
      chk("reset_full",  32'(bus.full),  32'd0);
      chk("reset_dout",  32'(bus.dout),  32'h00);

      // Fill with FF..F0, then attempt an overflow write of 11.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 1'b0, 8'(8'hFF - i), 1'b0, 8'h00);
         chk("fill_empty", 32'(bus.empty), 32'd0);
         chk("fill_full",  32'(bus.full),  (i == 15) ? 32'd1 : 32'd0);
      end
      step(1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 8'h00);
      chk("overflow_full",   32'(bus.full),   32'd1);
      chk("overflow_wr_ptr", 32'(dut.wr_ptr), 32'd16);

      // Drain: FF..F0 in order, one cycle after each read.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'(8'hFF - i));
         chk("drain_full",  32'(bus.full),  32'd0);
         chk("drain_empty", 32'(bus.empty), (i == 15) ? 32'd1 : 32'd0);
      end

      // Underflow: reads while empty are ignored and dout holds F0.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
         chk("underflow_empty", 32'(bus.empty), 32'd1);
      end
      chk("underflow_wr_ptr", 32'(dut.wr_ptr), 32'd16);
      chk("underflow_rd_ptr", 32'(dut.rd_ptr), 32'd16);

      // Wrap-around: write 10, read 10, then fill completely.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'(i), 1'b0, 8'h00);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'(i));
      chk("wrap_empty", 32'(bus.empty), 32'd1);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 8'h00);
      chk("wrap_full", 32'(bus.full), 32'd1);

      // Simultaneous access: first cycle is full so only the read lands and 50 is dropped;
      // afterwards occupancy is 15 and both sides are accepted.
      step(1'b0, 1'b1, 1'b1, 8'h50, 1'b1, 8'h20);
      chk("rw_full_after_read", 32'(bus.full), 32'd0);
      for (int i = 1; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b1, 8'(8'h50 + i), 1'b1, 8'(8'h20 + i));
         chk("rw_full",  32'(bus.full),  32'd0);
         chk("rw_empty", 32'(bus.empty), 32'd0);
      end
      for (int i = 4; i < 16; i++) step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'(8'h20 + i));
      for (int i = 1; i < 4; i++)  step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'(8'h50 + i));
      chk("rw_drained_empty", 32'(bus.empty), 32'd1);

      // Read and write together while empty: only the write lands, dout keeps 53.
      step(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00);
      chk("empty_rw_empty", 32'(bus.empty), 32'd0);
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h77);
      chk("empty_rw_after_read", 32'(bus.empty), 32'd1);

      // Reset mid-fill with requests asserted: reset wins and the contents are discarded.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 8'h00);
      chk("midreset_empty", 32'(bus.empty), 32'd1);
      chk("midreset_full",  32'(bus.full),  32'd0);
      step(1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5);
      chk("midreset_final_empty", 32'(bus.empty), 32'd1);

      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
